// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order FIFO of in-flight branch predictions.
// Pairs each resolution with the oldest entry and emits a registered
// training update (index, outcome, mispredict) one cycle later, and keeps
// saturating resolve/mispredict counters.
// Optional feature macro: BRQ_MISPRED_FLUSH_EN -- a mispredicting resolve
// also discards every younger (wrong-path) entry, including a same-cycle enqueue.
module branch_resolve_queue #(
  parameter int K     = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic [K-1:0]             pred_index,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_valid,
  output logic [K-1:0]             upd_index,
  output logic                     upd_outcome,
  output logic                     upd_mispredict,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [CNT_W-1:0]         total_cnt,
  output logic [CNT_W-1:0]         mispred_cnt,
  output logic                     orphan_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int QW = $clog2(DEPTH) + 1;

  logic [K-1:0]     idx_mem [DEPTH];
  logic [DEPTH-1:0] tkn_mem;
  logic [PW-1:0]    head, tail;
  logic             full, enq, deq, mis, flush;
  logic [QW-1:0]    count_nxt;

  // Full blocks enqueue for the whole cycle, even if a pop happens too.
  assign full       = (q_count == QW'(DEPTH));
  assign pred_ready = ~full;
  assign enq        = pred_valid & ~full;
  // Resolve is judged on start-of-cycle occupancy: no bypass of a same-cycle enqueue.
  assign deq        = res_valid & (q_count != '0);
  assign mis        = tkn_mem[head] ^ res_taken;

`ifdef BRQ_MISPRED_FLUSH_EN
  assign flush = deq & mis;
`else
  assign flush = 1'b0;
`endif

  // Next occupancy: +1 on enqueue, -1 on pop, cleared by a wrong-path flush.
  always_comb begin
    count_nxt = q_count;
    if (enq && !deq)
      count_nxt = q_count + QW'(1);
    else if (deq && !enq)
      count_nxt = q_count - QW'(1);
    if (flush)
      count_nxt = '0;
  end

  // Entry storage; no reset needed since occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (enq) begin
      idx_mem[tail] <= pred_index;
      tkn_mem[tail] <= pred_taken;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
    end else begin
      q_count <= count_nxt;
      if (flush) begin
        head <= head + PW'(1);
        tail <= head + PW'(1);
      end else begin
        if (deq) head <= head + PW'(1);
        if (enq) tail <= tail + PW'(1);
      end
    end
  end

  // Registered update pulse; payload holds its last value while upd_valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_valid      <= 1'b0;
      upd_index      <= '0;
      upd_outcome    <= 1'b0;
      upd_mispredict <= 1'b0;
    end else begin
      upd_valid <= deq;
      if (deq) begin
        upd_index      <= idx_mem[head];
        upd_outcome    <= res_taken;
        upd_mispredict <= mis;
      end
    end
  end

  // Saturating accuracy counters and the sticky orphan-resolve flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_cnt   <= '0;
      mispred_cnt <= '0;
      orphan_err  <= 1'b0;
    end else begin
      if (deq && total_cnt != '1)
        total_cnt <= total_cnt + CNT_W'(1);
      if (deq && mis && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      if (res_valid && q_count == '0)
        orphan_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: vector table, directed corner sequences
// and random traffic, all compared against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int K     = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int QW    = 3;
  localparam int SAT   = 15;
`ifdef BRQ_MISPRED_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             pred_valid, pred_taken, res_valid, res_taken;
  logic [K-1:0]     pred_index;
  logic             pred_ready, upd_valid, upd_outcome, upd_mispredict, orphan_err;
  logic [K-1:0]     upd_index;
  logic [QW-1:0]    q_count;
  logic [CNT_W-1:0] total_cnt, mispred_cnt;

  branch_resolve_queue #(.K(K), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_index(pred_index), .pred_taken(pred_taken),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_outcome(upd_outcome),
    .upd_mispredict(upd_mispredict), .q_count(q_count),
    .total_cnt(total_cnt), .mispred_cnt(mispred_cnt), .orphan_err(orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a plain queue of {index, predicted direction}.
  typedef struct { int idx; bit tk; } ent_t;
  ent_t mq[$];
  int   m_total, m_mis;
  bit   m_orph, m_uv, m_uo, m_um;
  int   m_ui;

  typedef struct {
    bit pv; int pi; bit pt; bit rv; bit rt;
    bit uv; int ui; bit um; int qc;
  } vec_t;
  vec_t tbl[7];

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_total = 0; m_mis = 0; m_orph = 0;
    m_uv = 0; m_ui = 0; m_uo = 0; m_um = 0;
  endtask

  task automatic model_step(bit pv, int pi, bit pt, bit rv, bit rt);
    bit   room, fl;
    ent_t e;
    room = (mq.size() < DEPTH);
    fl   = 0;
    m_uv = 0;
    if (rv && mq.size() > 0) begin
      e = mq.pop_front();
      m_uv = 1; m_ui = e.idx; m_uo = rt; m_um = e.tk ^ rt;
      if (m_total < SAT) m_total++;
      if (m_um && m_mis < SAT) m_mis++;
      if (FLUSH && m_um) fl = 1;
    end else if (rv) begin
      m_orph = 1;
    end
    if (pv && room) mq.push_back('{idx: pi, tk: pt});
    if (fl) mq.delete();
  endtask

  task automatic check_all(string tag);
    check({tag, ".q_count"},        int'(q_count),        mq.size());
    check({tag, ".pred_ready"},     int'(pred_ready),     int'(mq.size() < DEPTH));
    check({tag, ".upd_valid"},      int'(upd_valid),      int'(m_uv));
    check({tag, ".upd_index"},      int'(upd_index),      m_ui);
    check({tag, ".upd_outcome"},    int'(upd_outcome),    int'(m_uo));
    check({tag, ".upd_mispredict"}, int'(upd_mispredict), int'(m_um));
    check({tag, ".total_cnt"},      int'(total_cnt),      m_total);
    check({tag, ".mispred_cnt"},    int'(mispred_cnt),    m_mis);
    check({tag, ".orphan_err"},     int'(orphan_err),     int'(m_orph));
  endtask

  task automatic apply(string tag, bit pv, int pi, bit pt, bit rv, bit rt);
    pred_valid = pv; pred_index = pi[K-1:0]; pred_taken = pt;
    res_valid  = rv; res_taken  = rt;
    model_step(pv, pi, pt, rv, rt);
    @(posedge clk);
    #1;
    check_all(tag);
    pred_valid = 0; res_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pred_valid = 0; res_valid = 0; pred_index = '0; pred_taken = 0; res_taken = 0;
    model_clear();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // In-order resolve: 3/T, 7/N, 9/T resolved T, T, T.
    tbl[0] = '{pv:1, pi:3, pt:1, rv:0, rt:0, uv:0, ui:0, um:0, qc:1};
    tbl[1] = '{pv:1, pi:7, pt:0, rv:0, rt:0, uv:0, ui:0, um:0, qc:2};
    tbl[2] = '{pv:1, pi:9, pt:1, rv:0, rt:0, uv:0, ui:0, um:0, qc:3};
    tbl[3] = '{pv:0, pi:0, pt:0, rv:1, rt:1, uv:1, ui:3, um:0, qc:2};
    tbl[4] = '{pv:0, pi:0, pt:0, rv:1, rt:1, uv:1, ui:7, um:1, qc:1};
    tbl[5] = '{pv:0, pi:0, pt:0, rv:1, rt:1, uv:1, ui:9, um:0, qc:0};
    tbl[6] = '{pv:0, pi:0, pt:0, rv:0, rt:0, uv:0, ui:9, um:0, qc:0};

    pred_valid = 0; res_valid = 0; pred_index = '0; pred_taken = 0; res_taken = 0;
    reset = 1'b1;
    #1;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      apply("tbl", tbl[i].pv, tbl[i].pi, tbl[i].pt, tbl[i].rv, tbl[i].rt);
      check("tbl.uv", int'(upd_valid), int'(tbl[i].uv));
      if (tbl[i].uv) begin
        check("tbl.ui", int'(upd_index), tbl[i].ui);
        check("tbl.um", int'(upd_mispredict), int'(tbl[i].um));
      end
      check("tbl.qc", int'(q_count), tbl[i].qc);
    end
    check("tbl.total", int'(total_cnt), 3);
    check("tbl.mis", int'(mispred_cnt), 1);

    // Full queue: fifth request refused, resolve+enqueue pops only.
    do_reset();
    for (int i = 1; i <= 4; i++) apply("fill", 1, i, 0, 0, 0);
    check("full.ready", int'(pred_ready), 0);
    check("full.count", int'(q_count), 4);
    apply("full.5th", 1, 5, 0, 0, 0);
    check("full.5th.count", int'(q_count), 4);
    apply("full.pop", 1, 6, 0, 1, 0);
    check("full.pop.count", int'(q_count), 3);
    check("full.pop.idx", int'(upd_index), 1);
    check("full.pop.ready", int'(pred_ready), 1);
    apply("full.refill", 1, 6, 0, 0, 0);
    check("full.refill.count", int'(q_count), 4);
    for (int i = 0; i < 4; i++) apply("full.drain", 0, 0, 0, 1, 0);
    check("full.drain.last", int'(upd_index), 6);

    // Orphan resolve alongside an enqueue of idx 5.
    do_reset();
    apply("orphan", 1, 5, 0, 1, 1);
    check("orphan.uv", int'(upd_valid), 0);
    check("orphan.err", int'(orphan_err), 1);
    check("orphan.count", int'(q_count), 1);
    apply("orphan.late", 0, 0, 0, 1, 0);
    check("orphan.late.idx", int'(upd_index), 5);
    check("orphan.late.uv", int'(upd_valid), 1);

    // Steady state at two entries through pointer wrap.
    do_reset();
    apply("wrap.a", 1, 0, 1, 0, 0);
    apply("wrap.b", 1, 1, 0, 0, 0);
    for (int i = 2; i < 14; i++) begin
      apply("wrap", 1, i, i[0], 1, (i - 2) % 2 == 1);
      check("wrap.count", int'(q_count), 2);
      check("wrap.order", int'(upd_index), i - 2);
    end

    // Counter saturation, then asynchronous reset with entries queued.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply("sat.enq", 1, i % 16, 0, 0, 0);
      apply("sat.res", 0, 0, 0, 1, 1);
    end
    check("sat.total", int'(total_cnt), 15);
    check("sat.mis", int'(mispred_cnt), 15);
    for (int i = 0; i < 3; i++) apply("pre_rst", 1, 10 + i, 1, 0, 0);
    check("pre_rst.count", int'(q_count), 3);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply("post_rst", 0, 0, 0, 0, 0);

    // Mispredict on 1/T,2/T,3/N resolved N; flush only with the feature macro.
    do_reset();
    apply("fl.1", 1, 1, 1, 0, 0);
    apply("fl.2", 1, 2, 1, 0, 0);
    apply("fl.3", 1, 3, 0, 0, 0);
    apply("fl.res", 0, 0, 0, 1, 0);
    check("fl.idx", int'(upd_index), 1);
    check("fl.mis", int'(upd_mispredict), 1);
    check("fl.count", int'(q_count), FLUSH ? 0 : 2);
    for (int i = 0; i < 3; i++) apply("fl.after", 0, 0, 0, 1, 1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      apply("rand", $urandom_range(0, 99) < 60, $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 99) < 45, $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
